// File: rtl/memory_cycle.sv
// RISC-V M stage: issues one load/store at a time on a req/ack bus, aligns load data and registers the W stage.
// Latency: 1 cycle for non-memory/faulting ops, >=2 cycles for memory ops; StallM holds upstream while an access is pending.
module memory_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic        FaultW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic        memop;
    logic        fault;
    logic [1:0]  off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_c;

    always_comb begin
        memop = MemWriteM | ResultSrcM;
        off   = ALU_ResultM[1:0];
        fault = 1'b0;
        case (funct3M)
            3'b001, 3'b101:         fault = memop & off[0];
            3'b010:                 fault = memop & (off != 2'b00);
            3'b011, 3'b110, 3'b111: fault = memop;
            default:                fault = 1'b0;
        endcase
    end

    // Store lanes depend on access size; loads always fetch the whole word.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = 32'd0;
        if (MemWriteM) begin
            case (funct3M[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << off;
                    wdata_c = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << off;
                    wdata_c = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = WriteDataM;
                end
            endcase
        end
    end

    always_comb begin
        shifted  = mem_rdata >> {off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3M)
            3'b000:  load_c = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_c = {24'd0, byte_sel};
            3'b101:  load_c = {16'd0, half_sel};
            default: load_c = mem_rdata;
        endcase
    end

    assign StallM = ((state == IDLE) & memop & ~fault) | ((state == BUSY) & ~mem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'd0;
            mem_wdata   <= 32'd0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            FaultW      <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
        end else if (state == IDLE) begin
            if (memop && !fault) begin
                state      <= BUSY;
                mem_req    <= 1'b1;
                mem_we     <= MemWriteM;
                mem_addr   <= {ALU_ResultM[31:2], 2'b00};
                mem_be     <= be_c;
                mem_wdata  <= wdata_c;
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
                FaultW     <= 1'b0;
                RD_W       <= 5'd0;
            end else begin
                RegWriteW   <= RegWriteM & ~fault;
                ResultSrcW  <= ResultSrcM & ~fault;
                FaultW      <= fault;
                RD_W        <= RD_M;
                PCPlus4W    <= PCPlus4M;
                ALU_ResultW <= ALU_ResultM;
                ReadDataW   <= 32'd0;
            end
        end else begin
            // Bus outputs stay frozen until the ack; inputs are held stable by upstream.
            if (mem_ack) begin
                state       <= IDLE;
                mem_req     <= 1'b0;
                RegWriteW   <= RegWriteM;
                ResultSrcW  <= ResultSrcM;
                FaultW      <= 1'b0;
                RD_W        <= RD_M;
                PCPlus4W    <= PCPlus4M;
                ALU_ResultW <= ALU_ResultM;
                ReadDataW   <= mem_we ? 32'd0 : load_c;
            end else begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
                FaultW     <= 1'b0;
                RD_W       <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: drives at negedge, samples registered outputs at negedge and StallM 1ns later.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        RegWriteW, ResultSrcW, FaultW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .FaultW(FaultW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
    );

    task automatic clear_inputs();
        RegWriteM   = 1'b0;
        MemWriteM   = 1'b0;
        ResultSrcM  = 1'b0;
        funct3M     = 3'd0;
        RD_M        = 5'd0;
        PCPlus4M    = 32'd0;
        ALU_ResultM = 32'd0;
        WriteDataM  = 32'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
    endtask

    // Acts as upstream plus a memory that acks after ack_wait busy cycles; returns at the negedge after completion.
    task automatic run_access(input int ack_wait, output int stalls, output int reqs, output int unstable,
                              output logic done, output logic cap_we, output logic [3:0] cap_be,
                              output logic [31:0] cap_addr, output logic [31:0] cap_wdata);
        int   busy;
        logic seen;
        logic st;
        busy = 0; seen = 1'b0; stalls = 0; reqs = 0; unstable = 0; done = 1'b0;
        cap_we = 1'b0; cap_be = 4'd0; cap_addr = 32'd0; cap_wdata = 32'd0;
        for (int i = 0; i < 30 && !done; i++) begin
            mem_ack = mem_req && (busy == ack_wait);
            #1;
            st = StallM;
            if (st) stalls++;
            if (mem_req) begin
                reqs++;
                busy++;
                if (!seen) begin
                    seen = 1'b1;
                    cap_we = mem_we; cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {cap_we, cap_be, cap_addr, cap_wdata}) begin
                    unstable++;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (!st) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'd0) begin n_bad++; $display("FAIL reset_bus_ctl: got %b want 0", {mem_req, mem_we, mem_be}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'd0) begin n_bad++; $display("FAIL reset_bus_data: got %h want 0", {mem_addr, mem_wdata}); end
        n_cmp++; if ({RegWriteW, ResultSrcW, FaultW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0) begin
            n_bad++; $display("FAIL reset_w: got %h want 0", {RegWriteW, ResultSrcW, FaultW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW}); end
        n_cmp++; if (StallM !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", StallM); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        int st, rq, un; logic dn, we; logic [3:0] be; logic [31:0] ad, wd;
        RegWriteM = 1'b1; RD_M = 5'd5; ALU_ResultM = 32'h8; PCPlus4M = 32'h104;
        run_access(0, st, rq, un, dn, we, be, ad, wd);
        n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL alu_done: got %b want 1", dn); end
        n_cmp++; if (st != 0 || rq != 0) begin n_bad++; $display("FAIL alu_stall_req: got stalls=%0d reqs=%0d want 0 0", st, rq); end
        n_cmp++; if ({RegWriteW, RD_W, ALU_ResultW, PCPlus4W} !== {1'b1, 5'd5, 32'h8, 32'h104}) begin
            n_bad++; $display("FAIL alu_w: got rw=%b rd=%0d alu=%h pc=%h want 1 5 8 104", RegWriteW, RD_W, ALU_ResultW, PCPlus4W); end
        n_cmp++; if ({mem_req, FaultW, ResultSrcW} !== 3'b000) begin n_bad++; $display("FAIL alu_req: got %b want 000", {mem_req, FaultW, ResultSrcW}); end
        clear_inputs();
    endtask

    task automatic test_store();
        int st, rq, un; logic dn, we; logic [3:0] be; logic [31:0] ad, wd;
        MemWriteM = 1'b1; funct3M = 3'b000; ALU_ResultM = 32'h1003; WriteDataM = 32'hAB; RD_M = 5'd3;
        run_access(3, st, rq, un, dn, we, be, ad, wd);
        n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL sb_done: got %b want 1", dn); end
        n_cmp++; if (st != 4) begin n_bad++; $display("FAIL sb_stall_cycles: got %0d want 4", st); end
        n_cmp++; if (rq != 4 || un != 0) begin n_bad++; $display("FAIL sb_req_hold: got reqs=%0d unstable=%0d want 4 0", rq, un); end
        n_cmp++; if ({we, be, ad, wd} !== {1'b1, 4'b1000, 32'h1000, 32'hABABABAB}) begin
            n_bad++; $display("FAIL sb_bus: got we=%b be=%b addr=%h wdata=%h want 1 1000 00001000 abababab", we, be, ad, wd); end
        n_cmp++; if ({RD_W, RegWriteW, FaultW, mem_req} !== {5'd3, 3'b000}) begin
            n_bad++; $display("FAIL sb_w: got rd=%0d rw=%b flt=%b req=%b want 3 0 0 0", RD_W, RegWriteW, FaultW, mem_req); end
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (RD_W !== 5'd0) begin n_bad++; $display("FAIL sb_once: got rd=%0d want 0", RD_W); end

        MemWriteM = 1'b1; funct3M = 3'b001; ALU_ResultM = 32'h1002; WriteDataM = 32'hCAFE1234;
        run_access(1, st, rq, un, dn, we, be, ad, wd);
        n_cmp++; if (dn !== 1'b1 || st != 2) begin n_bad++; $display("FAIL sh_timing: got done=%b stalls=%0d want 1 2", dn, st); end
        n_cmp++; if ({be, ad, wd} !== {4'b1100, 32'h1000, 32'h12341234}) begin
            n_bad++; $display("FAIL sh_bus: got be=%b addr=%h wdata=%h want 1100 00001000 12341234", be, ad, wd); end
        clear_inputs();
    endtask

    task automatic test_load();
        logic [2:0]  f3 [5];
        logic [31:0] addr [5];
        logic [31:0] rdat [5];
        logic [31:0] expv [5];
        int st, rq, un; logic dn, we; logic [3:0] be; logic [31:0] ad, wd;
        f3[0] = 3'b000; addr[0] = 32'h2001; rdat[0] = 32'h0000F000; expv[0] = 32'hFFFFFFF0;
        f3[1] = 3'b100; addr[1] = 32'h2001; rdat[1] = 32'h0000F000; expv[1] = 32'h000000F0;
        f3[2] = 3'b001; addr[2] = 32'h2002; rdat[2] = 32'h80000000; expv[2] = 32'hFFFF8000;
        f3[3] = 3'b101; addr[3] = 32'h2002; rdat[3] = 32'h80000000; expv[3] = 32'h00008000;
        f3[4] = 3'b010; addr[4] = 32'h2004; rdat[4] = 32'hDEADBEEF; expv[4] = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd9;
            funct3M = f3[k]; ALU_ResultM = addr[k]; mem_rdata = rdat[k];
            run_access(0, st, rq, un, dn, we, be, ad, wd);
            n_cmp++; if (dn !== 1'b1 || st != 1) begin n_bad++; $display("FAIL load%0d_timing: got done=%b stalls=%0d want 1 1", k, dn, st); end
            n_cmp++; if (ReadDataW !== expv[k]) begin n_bad++; $display("FAIL load%0d_data: got %h want %h", k, ReadDataW, expv[k]); end
            n_cmp++; if ({RegWriteW, ResultSrcW, RD_W, we, be, ad} !== {2'b11, 5'd9, 1'b0, 4'b1111, addr[k] & 32'hFFFFFFFC}) begin
                n_bad++; $display("FAIL load%0d_ctl: got rw=%b rs=%b rd=%0d we=%b be=%b addr=%h", k, RegWriteW, ResultSrcW, RD_W, we, be, ad); end
            clear_inputs();
        end
    endtask

    task automatic test_fault();
        int st, rq, un; logic dn, we; logic [3:0] be; logic [31:0] ad, wd;
        RegWriteM = 1'b1; ResultSrcM = 1'b1; funct3M = 3'b010; ALU_ResultM = 32'h2002; RD_M = 5'd6;
        run_access(0, st, rq, un, dn, we, be, ad, wd);
        n_cmp++; if (dn !== 1'b1 || st != 0 || rq != 0) begin n_bad++; $display("FAIL lw_fault_timing: got done=%b stalls=%0d reqs=%0d want 1 0 0", dn, st, rq); end
        n_cmp++; if ({FaultW, RegWriteW, ResultSrcW, mem_req} !== 4'b1000) begin
            n_bad++; $display("FAIL lw_fault_w: got %b want 1000", {FaultW, RegWriteW, ResultSrcW, mem_req}); end
        clear_inputs();
        MemWriteM = 1'b1; funct3M = 3'b111; ALU_ResultM = 32'h3000;
        run_access(0, st, rq, un, dn, we, be, ad, wd);
        n_cmp++; if (dn !== 1'b1 || st != 0 || rq != 0 || FaultW !== 1'b1) begin
            n_bad++; $display("FAIL f3_fault: got done=%b stalls=%0d reqs=%0d flt=%b want 1 0 0 1", dn, st, rq, FaultW); end
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (FaultW !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b want 0", FaultW); end
    endtask

    task automatic test_reset_mid();
        RegWriteM = 1'b1; ResultSrcM = 1'b1; funct3M = 3'b010; ALU_ResultM = 32'h3000; RD_M = 5'd4; PCPlus4M = 32'h200;
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req_up: got %b want 1", mem_req); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0) begin
            n_bad++; $display("FAIL rmid_bus: got req=%b be=%b addr=%h", mem_req, mem_be, mem_addr); end
        n_cmp++; if ({RegWriteW, ResultSrcW, FaultW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0) begin
            n_bad++; $display("FAIL rmid_w: got rw=%b rd=%0d pc=%h alu=%h", RegWriteW, RD_W, PCPlus4W, ALU_ResultW); end
        clear_inputs();
        rst = 1'b0;
        mem_rdata = 32'h12345678;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if ({mem_req, StallM, RegWriteW, ResultSrcW, RD_W, ReadDataW} !== 41'd0) begin
            n_bad++; $display("FAIL rmid_late_ack: got req=%b stall=%b rw=%b rd=%0d rdata=%h", mem_req, StallM, RegWriteW, RD_W, ReadDataW); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  req_bits;
        logic [31:0] alu2;
        int idx, n1, n2;
        logic st;
        req_bits = 8'd0; alu2 = 32'd0; idx = 0; n1 = 0; n2 = 0;
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            if (idx == 0) begin
                MemWriteM = 1'b1; funct3M = 3'b010; ALU_ResultM = 32'h4000; WriteDataM = 32'h11223344; RD_M = 5'd1;
            end else if (idx == 1) begin
                MemWriteM = 1'b1; funct3M = 3'b010; ALU_ResultM = 32'h4004; WriteDataM = 32'h55667788; RD_M = 5'd2;
            end
            mem_ack = 1'b1;
            #1;
            req_bits[i] = mem_req;
            st = StallM;
            @(negedge clk);
            if (RD_W == 5'd1) n1++;
            if (RD_W == 5'd2) begin n2++; alu2 = ALU_ResultW; end
            if (!st && idx < 2) idx++;
        end
        clear_inputs();
        n_cmp++; if (req_bits !== 8'b0000_1010) begin n_bad++; $display("FAIL b2b_req_pattern: got %b want 00001010", req_bits); end
        n_cmp++; if (n1 != 1 || n2 != 1) begin n_bad++; $display("FAIL b2b_w_once: got n1=%0d n2=%0d want 1 1", n1, n2); end
        n_cmp++; if (alu2 !== 32'h4004) begin n_bad++; $display("FAIL b2b_second_addr: got %h want 00004004", alu2); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory-access (M) stage of the RISC-V pipeline core. It consumes the execute-stage pipeline register outputs, performs loads and stores over a req/ack data-memory bus with byte enables, and aligns and extends load data. It stalls upstream stages while an access is outstanding and registers the result into the writeback (W) stage.

## Interface
Parameters:
- none (32-bit datapath, 5-bit register index fixed)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- RegWriteM  in  1  instruction writes the register file
- MemWriteM  in  1  store
- ResultSrcM  in  1  load (1 = result comes from memory)
- funct3M  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD_M  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- ALU_ResultM  in  32  effective address, or ALU result for non-memory instructions
- WriteDataM  in  32  store data, byte-aligned to bit 0
- StallM  out  1  hold F/D/E and the M inputs stable
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address ({ALU_ResultM[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  one-cycle completion strobe; ignored unless mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack
- RegWriteW, ResultSrcW, FaultW  out  1 each  W-stage controls
- RD_W  out  5;  PCPlus4W, ALU_ResultW, ReadDataW  out  32  W-stage data

## Operation
- Memory op = MemWriteM | ResultSrcM. Fault: funct3 in {011,110,111}; H/HU with addr[0]=1; W with addr[1:0]≠0. A faulting op issues no bus access.
- FSM IDLE/BUSY.
  - IDLE, valid non-faulting memory op: register mem_req←1, mem_we←MemWriteM, mem_addr, mem_be, mem_wdata; go to BUSY. StallM=1 in this cycle; W register loads a bubble.
  - IDLE, otherwise: StallM=0; W register loads the instruction.
  - BUSY, mem_ack=0: hold all bus outputs stable; StallM=1; W loads a bubble.
  - BUSY, mem_ack=1: StallM=0. At the edge: mem_req←0, state←IDLE, W loads the instruction with ReadDataW = extracted mem_rdata (stores: ReadDataW=0).
- StallM = (IDLE & memop & ~fault) | (BUSY & ~mem_ack).
- Bubble: RegWriteW=0, ResultSrcW=0, FaultW=0, RD_W=0; data fields hold their previous values.
- Faulting op: completes in one cycle with FaultW=1, RegWriteW=0, ResultSrcW=0.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{WriteDataM[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{WriteDataM[15:0]}}.
  - SW: be=4'b1111, wdata=WriteDataM.
- Loads: mem_be=1111. Select byte addr[1:0] or halfword addr[1] of mem_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

## Timing
- Reset (synchronous, on any edge with rst=1, including mid-access): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; all W outputs 0. A later mem_ack for the abandoned access is ignored.
- Non-memory or faulting op: 1 cycle M→W.
- Memory op: minimum 2 cycles (issue cycle, then ack cycle). Each extra cycle without ack adds one cycle.
- mem_req rises on the edge after the op enters IDLE and falls on the edge after mem_ack. Only one access is outstanding at any time.
- Upstream must hold the M inputs constant while StallM=1. The block does not re-sample them in BUSY.
- Back-to-back memory ops: the second op is issued on the cycle after the first op's ack edge. mem_req is therefore low for one cycle between them.

## Test plan
- Reset, then ALU op, RD_M=5, ALU_ResultM=0x8 → next edge: RegWriteW=1, RD_W=5, ALU_ResultW=0x8, StallM=0 throughout, mem_req=0.
- SB at 0x1003, WriteDataM=0xAB, ack 3 cycles after req → mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000; StallM high 4 cycles; W shows one store with RegWriteW=0.
- LB at 0x2001, mem_rdata=0x0000F000 with immediate ack → ReadDataW=0xFFFFFFF0; the same access as LBU → 0x000000F0. LH at 0x2002 with rdata 0x80000000 → 0xFFFF8000.
- LW at 0x2002 → no mem_req, FaultW=1, RegWriteW=0, one cycle, StallM never asserted.
- rst asserted while BUSY, then mem_ack pulses after reset → mem_req=0 and all W outputs 0 after the reset edge; the late ack changes nothing.
- Two back-to-back SW with ack held 1 → exactly two mem_req pulses separated by one low cycle; each W instruction appears exactly once.
